// File: rtl/core_types_pkg.sv
// Shared core types: datapath width and the per-lane register-file write control word.
package core_types_pkg;

    localparam int N_BITS    = 32;
    localparam int RF_ADDR_W = 5;

    typedef struct packed {
        logic                 we;
        logic [RF_ADDR_W-1:0] waddr;
    } rf_ctrl_t;

endpackage

// File: rtl/wb_stage_multi_if.sv
// Bus bundle between the M stage, the multi-lane writeback stage and the register file.
// Carries retire_cnt only when WB_RETIRE_CNT_EN is defined.
interface wb_stage_multi_if #(
    parameter int N_LANES = 2,
    parameter int N_WP    = 1
);
    import core_types_pkg::*;

    rf_ctrl_t [N_LANES-1:0]        rf_ctrl_pkt_in;
    logic [N_LANES*N_BITS-1:0]     data_in;
    logic [N_LANES-1:0]            vld_in;
    logic                          stall_in;
    logic                          squash_in;

    logic [N_WP-1:0]               rf_wr_en;
    logic [N_WP*RF_ADDR_W-1:0]     rf_wr_addr;
    logic [N_WP*N_BITS-1:0]        rf_wr_data;
    logic [N_LANES-1:0]            vld;
    logic                          stall;
    logic                          squash;
    logic                          busy;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]                   retire_cnt;

    modport slave (
        input  rf_ctrl_pkt_in, data_in, vld_in, stall_in, squash_in,
        output rf_wr_en, rf_wr_addr, rf_wr_data, vld, stall, squash, busy, retire_cnt
    );
    modport master (
        output rf_ctrl_pkt_in, data_in, vld_in, stall_in, squash_in,
        input  rf_wr_en, rf_wr_addr, rf_wr_data, vld, stall, squash, busy, retire_cnt
    );
`else
    modport slave (
        input  rf_ctrl_pkt_in, data_in, vld_in, stall_in, squash_in,
        output rf_wr_en, rf_wr_addr, rf_wr_data, vld, stall, squash, busy
    );
    modport master (
        output rf_ctrl_pkt_in, data_in, vld_in, stall_in, squash_in,
        input  rf_wr_en, rf_wr_addr, rf_wr_data, vld, stall, squash, busy
    );
`endif

endinterface

// File: rtl/wb_port_select.sv
// Combinational picker: returns the indices of the first N_OUT set bits of req, lowest first,
// plus a per-output valid and the mask of selected request bits.
module wb_port_select #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 1,
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic [N_IN-1:0]             req,
    output logic [N_OUT-1:0][IDX_W-1:0] idx,
    output logic [N_OUT-1:0]            valid,
    output logic [N_IN-1:0]             grant
);

    always_comb begin
        int seen;
        seen  = 0;
        idx   = '0;
        valid = '0;
        grant = '0;
        for (int i = 0; i < N_IN; i++) begin
            for (int p = 0; p < N_OUT; p++) begin
                if (req[i] && (seen == p)) begin
                    idx[p]   = IDX_W'(i);
                    valid[p] = 1'b1;
                    grant[i] = 1'b1;
                end
            end
            if (req[i]) seen = seen + 1;
        end
    end

endmodule

// File: rtl/wb_stage_multi.sv
// Multi-lane writeback stage: captures a bundle of lane results and drains it over N_WP write
// ports, stalling upstream while a drain is in progress. Optional retire counter: WB_RETIRE_CNT_EN.
module wb_stage_multi
    import core_types_pkg::*;
#(
    parameter int N_LANES = 2,
    parameter int N_WP    = 1
) (
    input  logic            clk,
    input  logic            rst,
    wb_stage_multi_if.slave bus
);

    localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    logic [N_LANES-1:0]              vld_q;
    logic [N_LANES-1:0]              pend_q;
    logic [N_LANES-1:0]              pend_d;
    logic                            first_q;
    rf_ctrl_t [N_LANES-1:0]          ctrl_q;
    logic [N_LANES-1:0][N_BITS-1:0]  data_q;

    logic [N_WP-1:0][IDX_W-1:0]      port_idx;
    logic [N_WP-1:0]                 port_vld;
    logic [N_LANES-1:0]              grant;

    logic                            issue_en;
    logic                            gen_stall;
    logic                            stall_int;
    logic [N_LANES-1:0]              vld_int;

    // A lane is shadowed by any younger (higher-index) valid lane writing the same register.
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < N_LANES; i++) begin
            pend_d[i] = bus.vld_in[i] && bus.rf_ctrl_pkt_in[i].we &&
                        (bus.rf_ctrl_pkt_in[i].waddr != '0);
            for (int j = i + 1; j < N_LANES; j++) begin
                if (bus.vld_in[j] && bus.rf_ctrl_pkt_in[j].we &&
                    (bus.rf_ctrl_pkt_in[j].waddr == bus.rf_ctrl_pkt_in[i].waddr))
                    pend_d[i] = 1'b0;
            end
        end
    end

    wb_port_select #(
        .N_IN  (N_LANES),
        .N_OUT (N_WP)
    ) u_port_select (
        .req   (pend_q),
        .idx   (port_idx),
        .valid (port_vld),
        .grant (grant)
    );

    assign issue_en  = !rst && !bus.stall_in && !bus.squash_in;
    assign gen_stall = !rst && ($countones(pend_q) > N_WP);
    assign stall_int = bus.stall_in || gen_stall;

    assign bus.stall  = stall_int;
    assign bus.squash = bus.squash_in;
    assign bus.busy   = gen_stall;

    // Lanes that never write retire alongside the first issue cycle of their bundle.
    assign vld_int = issue_en ? (grant | (first_q ? (vld_q & ~pend_q) : '0)) : '0;
    assign bus.vld = vld_int;

    always_comb begin
        bus.rf_wr_en   = '0;
        bus.rf_wr_addr = '0;
        bus.rf_wr_data = '0;
        for (int p = 0; p < N_WP; p++) begin
            if (issue_en && port_vld[p]) begin
                bus.rf_wr_en[p]                           = 1'b1;
                bus.rf_wr_addr[p*RF_ADDR_W +: RF_ADDR_W]  = ctrl_q[port_idx[p]].waddr;
                bus.rf_wr_data[p*N_BITS +: N_BITS]        = data_q[port_idx[p]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            pend_q  <= '0;
            first_q <= 1'b0;
        end else if (bus.squash_in) begin
            vld_q   <= '0;
            pend_q  <= '0;
            first_q <= 1'b0;
        end else if (!stall_int) begin
            vld_q   <= bus.vld_in;
            pend_q  <= pend_d;
            first_q <= 1'b1;
        end else if (issue_en) begin
            pend_q  <= pend_q & ~grant;
            first_q <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed through vld_q/pend_q.
    always_ff @(posedge clk) begin
        if (!rst && !bus.squash_in && !stall_int) begin
            for (int i = 0; i < N_LANES; i++) begin
                ctrl_q[i] <= bus.rf_ctrl_pkt_in[i];
                data_q[i] <= bus.data_in[i*N_BITS +: N_BITS];
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) bus.retire_cnt <= '0;
        else     bus.retire_cnt <= bus.retire_cnt + 64'($countones(vld_int));
    end
`endif

endmodule

// File: tb/tb_wb_stage_multi.sv
// Directed bench for wb_stage_multi: one two-port and one single-port instance share stimulus.
module tb_wb_stage_multi;
    import core_types_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_stage_multi_if #(.N_LANES(2), .N_WP(2)) bus2 ();
    wb_stage_multi_if #(.N_LANES(2), .N_WP(1)) bus1 ();

    wb_stage_multi #(.N_LANES(2), .N_WP(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    wb_stage_multi #(.N_LANES(2), .N_WP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [1:0] v,
                              input logic we0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic we1, input logic [4:0] a1, input logic [31:0] d1);
        rf_ctrl_t c0, c1;
        c0 = '{we: we0, waddr: a0};
        c1 = '{we: we1, waddr: a1};
        bus2.vld_in = v;  bus2.rf_ctrl_pkt_in[0] = c0;  bus2.rf_ctrl_pkt_in[1] = c1;
        bus1.vld_in = v;  bus1.rf_ctrl_pkt_in[0] = c0;  bus1.rf_ctrl_pkt_in[1] = c1;
        bus2.data_in = {d1, d0};
        bus1.data_in = {d1, d0};
    endtask

    task automatic set_ctl(input logic st, input logic sq);
        bus2.stall_in = st;  bus2.squash_in = sq;
        bus1.stall_in = st;  bus1.squash_in = sq;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_bundle(2'b00, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset: outputs quiet, stall/squash pass through combinationally
        rst = 1'b1;
        set_bundle(2'b11, 1, 5'd5, 32'hA, 1, 5'd6, 32'hB);
        set_ctl(1, 1);
        tick();
        tick();
        #1;
        check_val("rst_stall",  bus1.stall,    1);
        check_val("rst_squash", bus1.squash,   1);
        check_val("rst_en",     bus2.rf_wr_en, 0);
        check_val("rst_vld",    bus2.vld,      0);
        check_val("rst_busy",   bus1.busy,     0);
        set_ctl(0, 0);
        #1;
        check_val("rst_stall_lo", bus2.stall, 0);
        do_reset();

        // Two-lane bundle: dual-port writes at once, single-port drains over two cycles
        set_bundle(2'b11, 1, 5'd5, 32'hA, 1, 5'd6, 32'hB);
        tick();
        set_bundle(2'b11, 1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
        #1;
        check_val("wp2_en",    bus2.rf_wr_en,   2'b11);
        check_val("wp2_addr",  bus2.rf_wr_addr, {5'd6, 5'd5});
        check_val("wp2_data",  bus2.rf_wr_data, {32'hB, 32'hA});
        check_val("wp2_vld",   bus2.vld,        2'b11);
        check_val("wp2_stall", bus2.stall,      0);
        check_val("wp1_c1_en",    bus1.rf_wr_en,   1);
        check_val("wp1_c1_addr",  bus1.rf_wr_addr, 5);
        check_val("wp1_c1_data",  bus1.rf_wr_data, 32'hA);
        check_val("wp1_c1_vld",   bus1.vld,        2'b01);
        check_val("wp1_c1_stall", bus1.stall,      1);
        check_val("wp1_c1_busy",  bus1.busy,       1);
        tick();
        #1;
        check_val("wp1_c2_en",    bus1.rf_wr_en,   1);
        check_val("wp1_c2_addr",  bus1.rf_wr_addr, 6);
        check_val("wp1_c2_data",  bus1.rf_wr_data, 32'hB);
        check_val("wp1_c2_vld",   bus1.vld,        2'b10);
        check_val("wp1_c2_stall", bus1.stall,      0);
        check_val("wp1_c2_busy",  bus1.busy,       0);
        // Collision bundle on the dual-port instance: only the younger lane writes
        check_val("col2_en",   bus2.rf_wr_en,   2'b01);
        check_val("col2_addr", bus2.rf_wr_addr, {5'd0, 5'd7});
        check_val("col2_data", bus2.rf_wr_data, {32'h0, 32'h2});
        check_val("col2_vld",  bus2.vld,        2'b11);
        tick();
        set_bundle(2'b00, 0, 0, 0, 0, 0, 0);
        #1;
        // Single-port instance only now sees the held collision bundle
        check_val("col1_en",    bus1.rf_wr_en,   1);
        check_val("col1_addr",  bus1.rf_wr_addr, 7);
        check_val("col1_data",  bus1.rf_wr_data, 32'h2);
        check_val("col1_vld",   bus1.vld,        2'b11);
        check_val("col1_stall", bus1.stall,      0);
        tick();
        #1;
        check_val("idle_en1",  bus1.rf_wr_en, 0);
        check_val("idle_vld1", bus1.vld,      0);
        check_val("idle_vld2", bus2.vld,      0);

        // x0 destination and we=0: retire without any write
        set_bundle(2'b11, 1, 5'd0, 32'hF, 0, 5'd3, 32'h5);
        tick();
        set_bundle(2'b00, 0, 0, 0, 0, 0, 0);
        #1;
        check_val("x0_en2",   bus2.rf_wr_en,   0);
        check_val("x0_addr2", bus2.rf_wr_addr, 0);
        check_val("x0_data2", bus2.rf_wr_data, 0);
        check_val("x0_vld2",  bus2.vld,        2'b11);
        check_val("x0_en1",   bus1.rf_wr_en,   0);
        check_val("x0_vld1",  bus1.vld,        2'b11);
        check_val("x0_stall", bus1.stall,      0);

        // stall_in holds the bundle with no writes
        do_reset();
        set_bundle(2'b11, 1, 5'd5, 32'hA, 1, 5'd6, 32'hB);
        tick();
        set_bundle(2'b00, 0, 0, 0, 0, 0, 0);
        set_ctl(1, 0);
        #1;
        check_val("stl_en",    bus2.rf_wr_en, 0);
        check_val("stl_vld",   bus2.vld,      0);
        check_val("stl_stall", bus2.stall,    1);
        tick();
        set_ctl(0, 0);
        #1;
        check_val("stl_rel_en",  bus2.rf_wr_en, 2'b11);
        check_val("stl_rel_vld", bus2.vld,      2'b11);

        // Squash during the first drain cycle
        do_reset();
        set_bundle(2'b11, 1, 5'd5, 32'hA, 1, 5'd6, 32'hB);
        tick();
        set_bundle(2'b00, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 1);
        #1;
        check_val("sq_en",     bus1.rf_wr_en, 0);
        check_val("sq_vld",    bus1.vld,      0);
        check_val("sq_squash", bus1.squash,   1);
        check_val("sq_en2",    bus2.rf_wr_en, 0);
        tick();
        set_ctl(0, 0);
        #1;
        check_val("sq_after_busy", bus1.busy,     0);
        check_val("sq_after_en",   bus1.rf_wr_en, 0);
        check_val("sq_after_vld",  bus1.vld,      0);
        tick();
        check_val("sq_after2_en",  bus1.rf_wr_en, 0);

        // Reset during the first drain cycle
        do_reset();
        set_bundle(2'b11, 1, 5'd5, 32'hA, 1, 5'd6, 32'hB);
        tick();
        set_bundle(2'b00, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check_val("rs_en",   bus1.rf_wr_en, 0);
        check_val("rs_vld",  bus1.vld,      0);
        check_val("rs_busy", bus1.busy,     0);
        tick();
        rst = 1'b0;
        #1;
        check_val("rs_after_busy", bus1.busy,     0);
        check_val("rs_after_en",   bus1.rf_wr_en, 0);
        check_val("rs_after_vld",  bus1.vld,      0);

`ifdef WB_RETIRE_CNT_EN
        do_reset();
        #1;
        check_val("cnt_rst", bus2.retire_cnt, 0);
        set_bundle(2'b11, 1, 5'd5, 32'hA, 1, 5'd6, 32'hB);
        tick();
        tick();
        tick();
        set_bundle(2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        set_ctl(1, 0);
        #1;
        check_val("cnt_six", bus2.retire_cnt, 6);
        tick();
        set_ctl(0, 0);
        #1;
        check_val("cnt_stall_hold", bus2.retire_cnt, 6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
